// File: rtl/cc_lane_pkg.sv
// Shared types, default timing constants and saturating helpers for the lane scheduler.
package cc_lane_pkg;

  localparam logic [1:0] CC_ST_RELOAD = 2'd0;
  localparam logic [1:0] CC_ST_RUN    = 2'd1;
  localparam logic [1:0] CC_ST_PAUSE  = 2'd2;

  typedef enum logic [1:0] {
    ST_RELOAD = CC_ST_RELOAD,
    ST_RUN    = CC_ST_RUN,
    ST_PAUSE  = CC_ST_PAUSE
  } cc_state_e;

  localparam int unsigned CC_LIMIT_BASE = 32'd50000;
  localparam int unsigned CC_LIMIT_STEP = 32'd4000;
  localparam int unsigned CC_LIMIT_MIN  = 32'd5000;
  localparam int unsigned CC_LANE_SKEW  = 32'd1500;

  // a - b, floored at floor_v; an underflow also lands on the floor.
  function automatic logic [31:0] cc_sat_sub(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] floor_v);
    logic [31:0] d;
    d = a - b;
    if (b > a || d < floor_v) cc_sat_sub = floor_v;
    else                      cc_sat_sub = d;
  endfunction

  function automatic logic [31:0] cc_sat_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) cc_sat_add = max_v;
    else                   cc_sat_add = s[31:0];
  endfunction

endpackage

// File: rtl/cc_lane_tick_counter.sv
// One lane: tick counter, limit register and registered 1-cycle shift pulse on wrap.
module cc_lane_tick_counter
  import cc_lane_pkg::*;
#(
  parameter int DATAWIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_clr,
  input  logic                 i_lim_we,
  input  logic [DATAWIDTH-1:0] i_lim,
  output logic                 o_shift
);

  logic [DATAWIDTH-1:0] r_cnt, r_lim;
  logic                 r_shift;
  logic                 w_hit;

  assign w_hit   = (r_cnt == r_lim);
  assign o_shift = r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_lim   <= '0;
      r_shift <= 1'b0;
    end else begin
      r_shift <= 1'b0;
      if (i_lim_we) r_lim <= i_lim;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_hit) begin
          r_cnt   <= '0;
          r_shift <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cc_lane_speed_scheduler.sv
// Per-lane motion scheduler: reloads lane limits from the level, one lane per cycle,
// then turns base ticks into per-lane shift pulses while running.
module cc_lane_speed_scheduler
  import cc_lane_pkg::*;
#(
  parameter int          LANES      = 4,
  parameter int          DATAWIDTH  = 16,
  parameter int          LEVELWIDTH = 3,
  parameter int unsigned LIMIT_BASE = CC_LIMIT_BASE,
  parameter int unsigned LIMIT_STEP = CC_LIMIT_STEP,
  parameter int unsigned LIMIT_MIN  = CC_LIMIT_MIN,
  parameter int unsigned LANE_SKEW  = CC_LANE_SKEW
) (
  input  logic                  CC_LANESCHEDULER_CLOCK_50,
  input  logic                  CC_LANESCHEDULER_RESET_InHigh,
  input  logic                  CC_LANESCHEDULER_tick_In,
  input  logic                  CC_LANESCHEDULER_run_In,
  input  logic [LEVELWIDTH-1:0] CC_LANESCHEDULER_level_InBUS,
  input  logic                  CC_LANESCHEDULER_levelLoad_In,
  output logic [LANES-1:0]      CC_LANESCHEDULER_shift_OutBUS,
  output logic                  CC_LANESCHEDULER_busy_Out,
  output logic [LEVELWIDTH-1:0] CC_LANESCHEDULER_level_OutBUS
);

  localparam int            IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);
  localparam logic [31:0]   LIM_MAX  = 32'((64'd1 << DATAWIDTH) - 64'd1);

  cc_state_e             r_state, w_nstate;
  logic [IW-1:0]         r_idx, w_nidx;
  logic [LEVELWIDTH-1:0] r_level;
  logic                  r_busy;
  logic                  w_lim_we, w_clr, w_tick_en;
  logic [31:0]           w_base;
  logic [DATAWIDTH-1:0]  w_lim;
  logic [LANES-1:0]      w_shift;

  // Limit for the lane currently being reloaded, from the applied level.
  assign w_base = cc_sat_sub(32'(LIMIT_BASE), 32'(r_level) * 32'(LIMIT_STEP), 32'(LIMIT_MIN));
  assign w_lim  = DATAWIDTH'(cc_sat_add(w_base, 32'(r_idx) * 32'(LANE_SKEW), LIM_MAX));

  always_comb begin
    w_nstate  = r_state;
    w_nidx    = r_idx;
    w_lim_we  = 1'b0;
    w_clr     = 1'b0;
    w_tick_en = 1'b0;
    if (CC_LANESCHEDULER_levelLoad_In) begin
      // Load wins over everything, including restarting a reload in progress.
      w_nstate = ST_RELOAD;
      w_nidx   = '0;
    end else begin
      unique case (r_state)
        ST_RELOAD: begin
          w_lim_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_clr    = 1'b1;
            w_nidx   = '0;
            w_nstate = CC_LANESCHEDULER_run_In ? ST_RUN : ST_PAUSE;
          end else begin
            w_nidx = r_idx + 1'b1;
          end
        end
        ST_RUN: begin
          if (!CC_LANESCHEDULER_run_In) w_nstate  = ST_PAUSE;
          else                          w_tick_en = CC_LANESCHEDULER_tick_In;
        end
        ST_PAUSE: begin
          if (CC_LANESCHEDULER_run_In) w_nstate = ST_RUN;
        end
        default: w_nstate = ST_RELOAD;
      endcase
    end
  end

  always_ff @(posedge CC_LANESCHEDULER_CLOCK_50 or posedge CC_LANESCHEDULER_RESET_InHigh) begin
    if (CC_LANESCHEDULER_RESET_InHigh) begin
      r_state <= ST_RELOAD;
      r_idx   <= '0;
      r_level <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_busy  <= (w_nstate == ST_RELOAD);
      if (CC_LANESCHEDULER_levelLoad_In) r_level <= CC_LANESCHEDULER_level_InBUS;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cc_lane_tick_counter #(.DATAWIDTH(DATAWIDTH)) u_cnt (
      .i_clk    (CC_LANESCHEDULER_CLOCK_50),
      .i_rst    (CC_LANESCHEDULER_RESET_InHigh),
      .i_tick   (w_tick_en),
      .i_clr    (w_clr),
      .i_lim_we (w_lim_we && (r_idx == IW'(g))),
      .i_lim    (w_lim),
      .o_shift  (w_shift[g])
    );
  end

  assign CC_LANESCHEDULER_shift_OutBUS = w_shift;
  assign CC_LANESCHEDULER_busy_Out     = r_busy;
  assign CC_LANESCHEDULER_level_OutBUS = r_level;

endmodule
